lcd_bus_capture: RTL and testbench

Synthesizable receiver for the calculator's character-LCD write bus (lcd_e, lcd_rs, lcd_rw, lcd_data). It decodes HD44780-style command and data writes into a 2x16 display shadow RAM, tracks the cursor, and exposes a read port and per-write event. It sits beside the calculator, either in the bench or on-chip as a display mirror, so key sequences such as 23 - 456 = can be checked against the characters actually written.

---
 rtl/lcd_bus_capture.sv | 181 ++++++++++++++++++
 tb/tb_lcd_bus_capture.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_capture.sv
// lcd_bus_capture: receiver for an HD44780-style character-LCD write bus.
// Decodes command and data writes into a 2x16 shadow of the display, tracks
// the DDRAM cursor, and exposes a registered read port and a per-write event.
// A clear-display command sweeps the shadow back to CLR_CHAR, one byte per cycle.
module lcd_bus_capture #(
    parameter logic [7:0] CLR_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_idx,
    output logic [7:0] rd_char,
    output logic [6:0] cursor,
    output logic       busy,
    output logic       wr_evt,
    output logic [4:0] wr_idx,
    output logic [7:0] wr_char,
    output logic       err
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic       e_d;
    logic       strobe;
    logic       inc, inc_nxt;
    logic [6:0] cursor_nxt;
    logic       err_nxt;
    logic [4:0] clr_k, clr_k_nxt;
    logic       evt_nxt;
    logic [4:0] cur_idx;
    logic       sh_we;
    logic [4:0] sh_widx;
    logic [7:0] sh_wdata;
    logic [7:0] shadow [32];

    // Cursor step between the two visible 16-character windows.
    function automatic logic [6:0] advance(input logic [6:0] addr, input logic up);
        if (up) begin
            if (addr == 7'h0F)      return 7'h40;
            else if (addr == 7'h4F) return 7'h00;
            else                    return addr + 7'd1;
        end else begin
            if (addr == 7'h40)      return 7'h0F;
            else if (addr == 7'h00) return 7'h4F;
            else                    return addr - 7'd1;
        end
    endfunction

    // A transfer is taken in the cycle after lcd_e was seen high and is now low.
    assign strobe  = e_d & ~lcd_e;
    assign cur_idx = {cursor[6], cursor[3:0]};
    assign busy    = (state == CLEAR);

    // Enable edge detector.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // register samples pre-edge values, independent of block ordering.
        if (!rst) e_d <= 1'b0;
        else      e_d <= lcd_e;
    end

    // State register for the IDLE/CLEAR machine and its sweep counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            clr_k <= 5'd0;
        end else begin
            state <= state_nxt;
            clr_k <= clr_k_nxt;
        end
    end

    // Next-state logic: strobe decode in IDLE, shadow sweep in CLEAR.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nxt  = state;
        clr_k_nxt  = clr_k;
        cursor_nxt = cursor;
        inc_nxt    = inc;
        err_nxt    = err;
        evt_nxt    = 1'b0;
        sh_we      = 1'b0;
        sh_widx    = cur_idx;
        sh_wdata   = lcd_data;

        case (state)
            IDLE: begin
                if (strobe) begin
                    if (lcd_rw) begin
                        // Reads are not serviced; flag the attempt.
                        err_nxt = 1'b1;
                    end else if (lcd_rs) begin
                        sh_we      = 1'b1;
                        evt_nxt    = 1'b1;
                        cursor_nxt = advance(cursor, inc);
                    end else begin
                        // Highest set bit selects the command.
                        casez (lcd_data)
                            8'b1???????: begin
                                if (lcd_data[5:4] == 2'b00) begin
                                    cursor_nxt = lcd_data[6:0];
                                end else begin
                                    cursor_nxt = 7'h00;
                                    err_nxt    = 1'b1;
                                end
                            end
                            8'b000001??: inc_nxt = lcd_data[1];
                            8'b0000001?: cursor_nxt = 7'h00;
                            8'b00000001: begin
                                cursor_nxt = 7'h00;
                                inc_nxt    = 1'b1;
                                clr_k_nxt  = 5'd0;
                                state_nxt  = CLEAR;
                            end
                            // CGRAM address, function set, shift, display
                            // control and 8'h00 leave the mirror untouched.
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR: begin
                sh_we     = 1'b1;
                sh_widx   = clr_k;
                sh_wdata  = CLR_CHAR;
                clr_k_nxt = clr_k + 5'd1;
                if (clr_k == 5'd31) state_nxt = IDLE;
                // The driver should have waited; drop the transfer and flag it.
                if (strobe) err_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Cursor, entry mode, sticky error and the data-write event registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cursor  <= 7'h00;
            inc     <= 1'b1;
            err     <= 1'b0;
            wr_evt  <= 1'b0;
            wr_idx  <= 5'd0;
            wr_char <= 8'h00;
        end else begin
            cursor <= cursor_nxt;
            inc    <= inc_nxt;
            err    <= err_nxt;
            wr_evt <= evt_nxt;
            if (evt_nxt) begin
                wr_idx  <= cur_idx;
                wr_char <= lcd_data;
            end
        end
    end

    // Shadow RAM: single write port shared by data writes and the clear sweep.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the shadow is reset as flops on purpose: the display mirror must
        // read CLR_CHAR immediately after reset, which a RAM macro cannot give.
        if (!rst) begin
            for (int i = 0; i < 32; i++) shadow[i] <= CLR_CHAR;
        end else if (sh_we) begin
            shadow[sh_widx] <= sh_wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_char <= 8'h00;
        else      rd_char <= shadow[rd_idx];
    end

endmodule

// File: tb/tb_lcd_bus_capture.sv
// Testbench for lcd_bus_capture: vector table for the basic write sequence,
// hand-written sequences for clear/reset corner cases, then randomized
// traffic checked against a behavioural model of the display.
module tb_lcd_bus_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic [4:0] rd_idx;
    logic [7:0] rd_char;
    logic [6:0] cursor;
    logic       busy;
    logic       wr_evt;
    logic [4:0] wr_idx;
    logic [7:0] wr_char;
    logic       err;

    int total = 0;
    int bad   = 0;

    lcd_bus_capture #(.CLR_CHAR(8'h20)) dut (
        .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .rd_idx(rd_idx), .rd_char(rd_char), .cursor(cursor),
        .busy(busy), .wr_evt(wr_evt), .wr_idx(wr_idx), .wr_char(wr_char), .err(err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_sh [32];
    int         m_cur;
    bit         m_inc;
    bit         m_err;
    bit         m_evt;
    int         m_widx;
    logic [7:0] m_wchar;
    bit         m_clear;

    function automatic int idx_of(int a);
        return ((a >= 64) ? 16 : 0) + (a % 16);
    endfunction

    function automatic int next_addr(int a, bit up);
        int line = a / 64;
        int col  = a % 16;
        if (up) return (col == 15) ? ((line != 0) ? 0 : 64) : a + 1;
        else    return (col == 0) ? ((line != 0) ? 15 : 79) : a - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_sh[i] = 8'h20;
        m_cur = 0; m_inc = 1; m_err = 0; m_evt = 0; m_widx = 0; m_wchar = 8'h00;
        m_clear = 0;
    endtask

    task automatic model_strobe(input bit rs, input bit rw, input logic [7:0] d);
        int hb;
        int a;
        m_evt = 0;
        m_clear = 0;
        if (rw) begin
            m_err = 1;
        end else if (rs) begin
            m_sh[idx_of(m_cur)] = d;
            m_evt = 1;
            m_widx = idx_of(m_cur);
            m_wchar = d;
            m_cur = next_addr(m_cur, m_inc);
        end else begin
            hb = -1;
            for (int b = 0; b < 8; b++) if (d[b]) hb = b;
            case (hb)
                7: begin
                    a = int'(d) - 128;
                    if (a < 16 || (a >= 64 && a < 80)) m_cur = a;
                    else begin m_cur = 0; m_err = 1; end
                end
                2: m_inc = d[1];
                1: m_cur = 0;
                0: begin
                    m_cur = 0; m_inc = 1; m_clear = 1;
                    for (int i = 0; i < 32; i++) m_sh[i] = 8'h20;
                end
                default: ;
            endcase
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the strobe cycle (N+1), when results are visible.
    task automatic drive_strobe(input bit rs, input bit rw, input logic [7:0] d);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        tick();
        lcd_e = 1'b0;
        tick();
    endtask

    task automatic xfer_model(input bit rs, input bit rw, input logic [7:0] d);
        drive_strobe(rs, rw, d);
        model_strobe(rs, rw, d);
        check("cursor", cursor, m_cur);
        check("err", err, m_err);
        check("wr_evt", wr_evt, m_evt);
        if (m_evt) begin
            check("wr_idx", wr_idx, m_widx);
            check("wr_char", wr_char, m_wchar);
        end
    endtask

    task automatic read_at(input int i, output logic [7:0] v);
        rd_idx = i[4:0];
        tick();
        v = rd_char;
    endtask

    task automatic sweep_model(input string name);
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            read_at(i, v);
            check(name, v, m_sh[i]);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         rs;
        bit         rw;
        logic [7:0] data;
        logic [6:0] cur;
        bit         evt;
        logic [4:0] widx;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [7:0] v;

        rst = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
        lcd_data = 8'h00; rd_idx = 5'd0;
        model_reset();

        tbl[0]  = '{0, 0, 8'h38, 7'h00, 0, 5'd0};
        tbl[1]  = '{0, 0, 8'h0C, 7'h00, 0, 5'd0};
        tbl[2]  = '{0, 0, 8'h06, 7'h00, 0, 5'd0};
        tbl[3]  = '{1, 0, 8'h32, 7'h01, 1, 5'd0};
        tbl[4]  = '{1, 0, 8'h33, 7'h02, 1, 5'd1};
        tbl[5]  = '{1, 0, 8'h2D, 7'h03, 1, 5'd2};
        tbl[6]  = '{0, 0, 8'h8F, 7'h0F, 0, 5'd0};
        tbl[7]  = '{1, 0, 8'h41, 7'h40, 1, 5'd15};
        tbl[8]  = '{1, 0, 8'h42, 7'h41, 1, 5'd16};
        tbl[9]  = '{0, 0, 8'h04, 7'h41, 0, 5'd0};
        tbl[10] = '{0, 0, 8'h80, 7'h00, 0, 5'd0};
        tbl[11] = '{1, 0, 8'h78, 7'h4F, 1, 5'd0};

        // Values while reset is held.
        repeat (2) tick();
        check("rst_rd_char", rd_char, 8'h00);
        check("rst_cursor", cursor, 7'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_evt", wr_evt, 1'b0);
        check("rst_wr_idx", wr_idx, 5'd0);
        check("rst_wr_char", wr_char, 8'h00);
        check("rst_err", err, 1'b0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 32; i++) begin
            read_at(i, v);
            check("init_shadow", v, 8'h20);
        end
        check("init_cursor", cursor, 7'h00);
        check("init_busy", busy, 1'b0);
        check("init_err", err, 1'b0);

        // Table: command/data write sequence with cursor wraps.
        for (int i = 0; i < 12; i++) begin
            drive_strobe(tbl[i].rs, tbl[i].rw, tbl[i].data);
            model_strobe(tbl[i].rs, tbl[i].rw, tbl[i].data);
            check("tbl_cursor", cursor, tbl[i].cur);
            check("tbl_evt", wr_evt, tbl[i].evt);
            check("tbl_err", err, 1'b0);
            if (tbl[i].evt) begin
                check("tbl_wr_idx", wr_idx, tbl[i].widx);
                check("tbl_wr_char", wr_char, tbl[i].data);
            end
            tick();
            check("tbl_evt_off", wr_evt, 1'b0);
        end
        read_at(0, v);  check("sh0", v, 8'h78);
        read_at(1, v);  check("sh1", v, 8'h33);
        read_at(2, v);  check("sh2", v, 8'h2D);
        read_at(3, v);  check("sh3", v, 8'h20);
        read_at(15, v); check("sh15", v, 8'h41);
        read_at(16, v); check("sh16", v, 8'h42);
        read_at(31, v); check("sh31", v, 8'h20);

        // lcd_e held high: nothing until the falling edge, then exactly one write.
        lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h48; lcd_e = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("hold_no_evt", wr_evt, 1'b0);
        end
        check("hold_cursor", cursor, 7'h4F);
        lcd_e = 1'b0;
        tick();
        model_strobe(1, 0, 8'h48);
        check("hold_evt", wr_evt, 1'b1);
        check("hold_cursor_after", cursor, m_cur);
        check("hold_wr_idx", wr_idx, 5'd31);
        repeat (3) begin
            tick();
            check("hold_single", wr_evt, 1'b0);
        end

        // Clear at N with a data strobe at N+5 inside the sweep.
        drive_strobe(0, 0, 8'h01);
        model_strobe(0, 0, 8'h01);
        for (int c = 1; c <= 40; c++) begin
            check($sformatf("clr_busy_%0d", c), busy, (c <= 32));
            check("clr_no_evt", wr_evt, 1'b0);
            if (c == 4) begin
                lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h51; lcd_e = 1'b1;
            end
            if (c == 5) lcd_e = 1'b0;
            tick();
        end
        m_err = 1;
        check("clr_err", err, 1'b1);
        check("clr_cursor", cursor, 7'h00);
        sweep_model("clr_shadow");

        // Invalid DDRAM address.
        do_reset();
        xfer_model(0, 0, 8'h85);
        check("addr_valid", cursor, 7'h05);
        xfer_model(0, 0, 8'h95);
        check("addr_bad_cursor", cursor, 7'h00);
        check("addr_bad_err", err, 1'b1);

        // Read strobe is ignored apart from the error flag.
        do_reset();
        xfer_model(0, 0, 8'hC7);
        xfer_model(0, 1, 8'h55);
        check("rw_cursor", cursor, 7'h47);
        check("rw_err", err, 1'b1);
        sweep_model("rw_shadow");

        // Reset asserted at N+10 of a sweep.
        drive_strobe(1, 0, 8'h61);
        model_strobe(1, 0, 8'h61);
        drive_strobe(0, 0, 8'h01);
        repeat (9) tick();
        check("mid_busy_pre", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_busy", busy, 1'b0);
        check("mid_err", err, 1'b0);
        check("mid_cursor", cursor, 7'h00);
        tick();
        rst = 1'b1;
        tick();
        model_reset();
        xfer_model(1, 0, 8'h5A);
        read_at(0, v); check("mid_sh0", v, 8'h5A);
        read_at(7, v); check("mid_sh7", v, 8'h20);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int r;
            bit rs;
            bit rw;
            logic [7:0] d;
            r  = $urandom_range(0, 99);
            rs = 0; rw = 0; d = 8'($urandom);
            if (r < 4) rw = 1;
            else if (r < 55) rs = 1;
            else if (r < 58) d = 8'h01;
            else if (r < 75) d = {1'b1, 7'($urandom)};
            else if (r < 85) d = {6'b000001, 2'($urandom)};
            else if (r < 90) d = {7'b0000001, 1'($urandom)};
            else if (d == 8'h01) d = 8'h00;
            xfer_model(rs, rw, d);
            if (m_clear) begin
                repeat (32) tick();
                check("rnd_clear_done", busy, 1'b0);
            end
            repeat ($urandom_range(0, 2)) tick();
            if (n % 40 == 39) begin
                int k;
                k = $urandom_range(0, 31);
                read_at(k, v);
                check("rnd_read", v, m_sh[k]);
            end
        end
        sweep_model("rnd_shadow");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
